// File: rtl/comp_pkg.sv
// comp_pkg: shared result encoding, stage flags and sizing helper for the pipelined comparator
package comp_pkg;

    typedef enum logic [2:0] {
        RES_NONE = 3'b000,
        RES_GT   = 3'b100,
        RES_EQ   = 3'b010,
        RES_LT   = 3'b001
    } res_e;

    // Decision flags carried down the pipe; operand chunks travel in parallel registers in the top
    typedef struct packed {
        logic valid;
        logic decided;
        logic gt;
    } stage_t;

    function automatic int nstg(input int w, input int chunk);
        return (w + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/comp_slice_stage.sv
// comp_slice_stage: resolves one operand chunk, holding its contents while stalled
module comp_slice_stage import comp_pkg::*; #(
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  stage_t           d,
    input  logic [CHUNK-1:0] ca,
    input  logic [CHUNK-1:0] cb,
    output stage_t           q
);

    // the first differing chunk decides; once decided, later chunks leave the flags alone
    always_ff @(posedge CLK)
        if (RST)
            q <= '0;
        else if (en)
            q <= (d.decided || ca == cb) ? d : stage_t'{valid: d.valid, decided: 1'b1, gt: ca > cb};

endmodule

// File: rtl/comp_pipe.sv
// comp_pipe: pipelined signed/unsigned magnitude comparator with handshake and saturating result counters
module comp_pipe import comp_pkg::*; #(
    parameter int W     = 16,
    parameter int CHUNK = 4,
    parameter int CW    = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [W-1:0]  A,
    input  logic [W-1:0]  B,
    input  logic          S,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic          Greater,
    output logic          Equal,
    output logic          Smaller,
    input  logic          CLR,
    output logic [CW-1:0] CNT_GT,
    output logic [CW-1:0] CNT_EQ,
    output logic [CW-1:0] CNT_LT
);

    localparam int NSTG = nstg(W, CHUNK);
    localparam int P    = NSTG * CHUNK;

    stage_t       st   [NSTG+1];
    logic [P-1:0] a_op [NSTG];
    logic [P-1:0] b_op [NSTG];
    logic [W-1:0] a_m;
    logic [W-1:0] b_m;
    logic         deliver;
    res_e         res;

    assign OUT_VALID = st[NSTG].valid;
    assign IN_READY  = !(OUT_VALID && !OUT_READY);
    assign deliver   = OUT_VALID && OUT_READY;
    assign a_m       = A ^ (W'(S) << (W - 1));
    assign b_m       = B ^ (W'(S) << (W - 1));

    // input stage flags: a bubble enters whenever nothing is offered
    always_ff @(posedge CLK)
        if (RST)
            st[0] <= '0;
        else if (IN_READY)
            st[0] <= stage_t'{valid: IN_VALID, decided: 1'b0, gt: 1'b0};

    // operand delay line, MSB-aligned so LSB zero padding fills the last chunk
    always_ff @(posedge CLK)
        if (IN_READY) begin
            a_op[0] <= P'(a_m) << (P - W);
            b_op[0] <= P'(b_m) << (P - W);
            for (int i = 1; i < NSTG; i++) begin
                a_op[i] <= a_op[i-1];
                b_op[i] <= b_op[i-1];
            end
        end

    for (genvar k = 1; k <= NSTG; k++) begin : g_stg
        comp_slice_stage #(.CHUNK(CHUNK)) u_stg (
            .CLK (CLK),
            .RST (RST),
            .en  (IN_READY),
            .d   (st[k-1]),
            .ca  (a_op[k-1][P-k*CHUNK +: CHUNK]),
            .cb  (b_op[k-1][P-k*CHUNK +: CHUNK]),
            .q   (st[k])
        );
    end

    // outcome decode from the last stage registers only
    always_comb
        res = !OUT_VALID ? RES_NONE : !st[NSTG].decided ? RES_EQ : st[NSTG].gt ? RES_GT : RES_LT;

    assign {Greater, Equal, Smaller} = res;

    // per-outcome delivery counters; clear wins over a same-cycle delivery, saturate at all-ones
    always_ff @(posedge CLK)
        if (RST || CLR) begin
            CNT_GT <= '0;
            CNT_EQ <= '0;
            CNT_LT <= '0;
        end else if (deliver) begin
            if (Greater && CNT_GT != '1) CNT_GT <= CNT_GT + 1'b1;
            if (Equal && CNT_EQ != '1) CNT_EQ <= CNT_EQ + 1'b1;
            if (Smaller && CNT_LT != '1) CNT_LT <= CNT_LT + 1'b1;
        end

endmodule
